// File: rtl/mem_regf.sv
// mem_regf -- general-purpose register file for the SXP processor.
//
// Two independent registered read ports (A, B) and one write port (C).
// Storage is duplicated into two identical banks so each read port owns a
// simple dual-port memory (one write, one read): port C writes both banks,
// bank 0 serves port A and bank 1 serves port B.
//
// Ports:
//   clk      in   1      clock, all state updates on the rising edge
//   reset_b  in   1      asynchronous reset, active HIGH (clears qra/qrb only)
//   halt     in   1      pipeline stall: no writes, both outputs hold
//   addra    in   WIDTH  read port A address
//   a_en     in   1      read port A enable
//   addrb    in   WIDTH  read port B address
//   b_en     in   1      read port B enable
//   addrc    in   WIDTH  write port C address
//   wec      in   1      write port C enable
//   dc       in   32     write port C data
//   qra      out  32     read port A data, one cycle latency
//   qrb      out  32     read port B data, one cycle latency
//
// Register contents are never cleared by reset; software initialises them.
// A read of the address being written on the same edge returns the new data.

module mem_regf #(
  parameter int WIDTH = 4,
  parameter int SIZE  = 16
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             halt,
  input  logic [WIDTH-1:0] addra,
  input  logic             a_en,
  input  logic [WIDTH-1:0] addrb,
  input  logic             b_en,
  input  logic [WIDTH-1:0] addrc,
  input  logic             wec,
  input  logic [31:0]      dc,
  output logic [31:0]      qra,
  output logic [31:0]      qrb
);

  // Address range check for the write port. When SIZE fills the whole
  // address space every address is valid and no comparator is needed.
  logic wr_in_range;

  generate
    if (SIZE >= (1 << WIDTH)) begin : g_full
      assign wr_in_range = 1'b1;
    end else begin : g_partial
      assign wr_in_range = (32'(addrc) < 32'(SIZE));
    end
  endgenerate

  // A write commits only outside halt and outside reset: a write presented
  // on an edge where reset is asserted is discarded.
  logic wr_ok;
  assign wr_ok = wec && !halt && !reset_b && wr_in_range;

  // One bank plus output register per read port; gi = 0 is port A, 1 is B.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic [WIDTH-1:0] rd_addr;
      logic             rd_en;
      logic [31:0]      bank [SIZE];
      logic [31:0]      q_reg;

      assign rd_addr = (gi == 0) ? addra : addrb;
      assign rd_en   = (gi == 0) ? a_en  : b_en;

      // Memory array: no reset so it maps onto block RAM.
      always_ff @(posedge clk) begin
        if (wr_ok) begin
          bank[addrc] <= dc;
        end
      end

      // Registered read with write-first bypass on an address match.
      always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) begin
          q_reg <= 32'd0;
        end else if (!halt && rd_en) begin
          if (wr_ok && (addrc == rd_addr)) begin
            q_reg <= dc;
          end else begin
            q_reg <= bank[rd_addr];
          end
        end
      end
    end
  endgenerate

  assign qra = g_port[0].q_reg;
  assign qrb = g_port[1].q_reg;

endmodule

// File: tb/tb_mem_regf.sv
// tb_mem_regf -- directed self-checking bench for mem_regf.
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns after
// the following rising edge (or between edges for the async reset checks).

module tb_mem_regf;

  localparam int WIDTH = 4;
  localparam int SIZE  = 16;

  logic             clk = 1'b0;
  logic             reset_b;
  logic             halt;
  logic [WIDTH-1:0] addra;
  logic             a_en;
  logic [WIDTH-1:0] addrb;
  logic             b_en;
  logic [WIDTH-1:0] addrc;
  logic             wec;
  logic [31:0]      dc;
  logic [31:0]      qra;
  logic [31:0]      qrb;

  int tests = 0;
  int fails = 0;

  mem_regf #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .halt    (halt),
    .addra   (addra),
    .a_en    (a_en),
    .addrb   (addrb),
    .b_en    (b_en),
    .addrc   (addrc),
    .wec     (wec),
    .dc      (dc),
    .qra     (qra),
    .qrb     (qrb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("[TB] %-10s obs=%0d exp=%0d", tag, obs, exp);
  endtask

  initial begin
    logic [31:0] expa;
    logic [31:0] expb;

    reset_b = 1'b0;
    halt    = 1'b0;
    addra   = '0;
    a_en    = 1'b0;
    addrb   = '0;
    b_en    = 1'b0;
    addrc   = '0;
    wec     = 1'b0;
    dc      = '0;

    // Async reset before any clock edge.
    #2 reset_b = 1'b1;
    #1;
    chk("rst_a", qra, 32'd0);
    chk("rst_b", qrb, 32'd0);
    tick();
    tick();
    reset_b = 1'b0;

    // 1: write i into reg i.
    for (int i = 0; i < 16; i++) begin
      addrc = 4'(i);
      dc    = 32'(i);
      wec   = 1'b1;
      tick();
    end
    wec = 1'b0;

    // 1-4: read sweep; collision at i=5, halt (with blocked write) before i=7.
    for (int i = 0; i < 16; i++) begin
      if (i == 7) begin
        halt  = 1'b1;
        addra = 4'd7;
        addrb = 4'd8;
        wec   = 1'b1;
        addrc = 4'd3;
        dc    = 32'd99;
        repeat (4) begin
          tick();
          chk("halt_a", qra, 32'd6);
          chk("halt_b", qrb, 32'd9);
        end
        halt = 1'b0;
        wec  = 1'b0;
      end
      addra = 4'(i);
      addrb = 4'(15 - i);
      a_en  = 1'b1;
      b_en  = 1'b1;
      wec   = (i == 5);
      addrc = 4'd5;
      dc    = 32'd1234;
      tick();
      wec  = 1'b0;
      expa = (i == 5) ? 32'd1234 : 32'(i);
      expb = (i == 10) ? 32'd1234 : 32'(15 - i);
      chk("sweep_a", qra, expa);
      chk("sweep_b", qrb, expb);
    end

    // 5: both enables low -> outputs hold.
    a_en  = 1'b0;
    b_en  = 1'b0;
    addra = 4'd1;
    addrb = 4'd2;
    tick();
    chk("hold_a", qra, 32'd15);
    chk("hold_b", qrb, 32'd0);
    tick();
    chk("hold_a2", qra, 32'd15);
    chk("hold_b2", qrb, 32'd0);

    // Port A alone; reg 3 must not have taken the write issued under halt.
    a_en  = 1'b1;
    addra = 4'd3;
    tick();
    chk("reg3_a", qra, 32'd3);
    chk("onlya_b", qrb, 32'd0);

    // Both ports on the same register.
    b_en  = 1'b1;
    addra = 4'd9;
    addrb = 4'd9;
    tick();
    chk("same_a", qra, 32'd9);
    chk("same_b", qrb, 32'd9);

    // Port B write-first bypass while port A is disabled.
    a_en  = 1'b0;
    addrb = 4'd12;
    addrc = 4'd12;
    dc    = 32'hCAFE;
    wec   = 1'b1;
    tick();
    wec = 1'b0;
    chk("byp_b", qrb, 32'hCAFE);
    chk("byp_a_hold", qra, 32'd9);
    a_en  = 1'b1;
    addra = 4'd12;
    tick();
    chk("reg12_a", qra, 32'hCAFE);

    // Register 0 is writable.
    addrc = 4'd0;
    dc    = 32'hDEADBEEF;
    wec   = 1'b1;
    a_en  = 1'b0;
    b_en  = 1'b0;
    tick();
    wec   = 1'b0;
    addra = 4'd0;
    a_en  = 1'b1;
    tick();
    chk("reg0_a", qra, 32'hDEADBEEF);

    // Reg 5 keeps the collision value.
    addra = 4'd5;
    addrb = 4'd2;
    b_en  = 1'b1;
    tick();
    chk("reg5_a", qra, 32'd1234);
    chk("reg2_b", qrb, 32'd2);

    // 6: reset mid-operation, between edges, with a write pending.
    #3 reset_b = 1'b1;
    wec   = 1'b1;
    addrc = 4'd2;
    dc    = 32'd777;
    #1;
    chk("mrst_a", qra, 32'd0);
    chk("mrst_b", qrb, 32'd0);
    tick();
    chk("mrst_a2", qra, 32'd0);
    chk("mrst_b2", qrb, 32'd0);
    reset_b = 1'b0;
    wec     = 1'b0;
    addra   = 4'd2;
    addrb   = 4'd5;
    tick();
    chk("post_a", qra, 32'd2);
    chk("post_b", qrb, 32'd1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
